// File: rtl/mem_arbiter_if.sv
// Request/ack ports for the IF and MEM clients plus the 16-bit SRAM bus.
// slave = arbiter side, master = clients and SRAM model side.
interface mem_arbiter_if #(parameter int ADDR_W = 18);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_rdata;
  logic              if_ack;
  logic              stall_if;
  logic              mem_req;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;
  logic              stall_mem;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wre;
  logic              ram_oe;
  logic [15:0]       ram_wdata;
  logic [15:0]       ram_rdata;

  modport slave (
    input  if_req, if_addr, mem_req, mem_rw, mem_addr, mem_wdata, ram_rdata,
    output if_rdata, if_ack, stall_if, mem_rdata, mem_ack, stall_mem,
           ram_addr, ram_wre, ram_oe, ram_wdata
  );

  modport master (
    output if_req, if_addr, mem_req, mem_rw, mem_addr, mem_wdata, ram_rdata,
    input  if_rdata, if_ack, stall_if, mem_rdata, mem_ack, stall_mem,
           ram_addr, ram_wre, ram_oe, ram_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one 16-bit SRAM between IF and MEM ports; each 32-bit access is a
// low-half then high-half RAM cycle, MEM preferred with an IF anti-starvation count.
module mem_arbiter #(
  parameter int ADDR_W     = 18,
  parameter int STARVE_MAX = 4
) (
  input  logic clock,
  input  logic reset,
  mem_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              own_mem_q, own_mem_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-2:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [15:0]       lo_q, lo_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic              grant_if;
  logic              if_ack_c, mem_ack_c;
  logic              unused_addr_lsb;

  // Halfword select comes from the FSM phase, so address bit 0 is never used.
  assign unused_addr_lsb = bus.if_addr[0] ^ bus.mem_addr[0];

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    own_mem_d     = own_mem_q;
    rd_d          = rd_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    lo_d          = lo_q;
    if_rdata_d    = if_rdata_q;
    mem_rdata_d   = mem_rdata_q;
    if_ack_c      = 1'b0;
    mem_ack_c     = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wre   = 1'b0;
    bus.ram_oe    = 1'b0;
    bus.ram_wdata = '0;
    grant_if      = bus.if_req & (~bus.mem_req | (cnt_q == CNT_MAX));
    case (state_q)
      IDLE: begin
        if (bus.if_req | bus.mem_req) begin
          state_d   = LO;
          own_mem_d = ~grant_if;
          if (grant_if) begin
            rd_d    = 1'b1;
            addr_d  = bus.if_addr[ADDR_W-1:1];
            wdata_d = '0;
            cnt_d   = '0;
          end else begin
            rd_d    = bus.mem_rw;
            addr_d  = bus.mem_addr[ADDR_W-1:1];
            wdata_d = bus.mem_wdata;
            if (bus.if_req && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          end
        end
      end
      LO: begin
        bus.ram_addr = {addr_q, 1'b0};
        if (rd_q) begin
          lo_d = bus.ram_rdata;
        end else begin
          bus.ram_wre   = 1'b1;
          bus.ram_oe    = 1'b1;
          bus.ram_wdata = wdata_q[15:0];
        end
        state_d = HI;
      end
      HI: begin
        bus.ram_addr = {addr_q, 1'b1};
        // Result lands in the owner's register here so it is valid during the ack.
        if (rd_q) begin
          if (own_mem_q) mem_rdata_d = {bus.ram_rdata, lo_q};
          else           if_rdata_d  = {bus.ram_rdata, lo_q};
        end else begin
          bus.ram_wre   = 1'b1;
          bus.ram_oe    = 1'b1;
          bus.ram_wdata = wdata_q[31:16];
        end
        state_d = DONE;
      end
      DONE: begin
        if_ack_c  = ~own_mem_q;
        mem_ack_c = own_mem_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      own_mem_q   <= 1'b0;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lo_q        <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      own_mem_q   <= own_mem_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      lo_q        <= lo_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign bus.if_rdata  = if_rdata_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.if_ack    = if_ack_c;
  assign bus.mem_ack   = mem_ack_c;
  assign bus.stall_if  = bus.if_req & ~if_ack_c;
  assign bus.stall_mem = bus.mem_req & ~mem_ack_c;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, corner-case sequences and a
// randomized phase checked against a transaction-level timing/memory model.
module tb_mem_arbiter;
  logic clock;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  mem_arbiter_if #(.ADDR_W(18)) bus ();
  mem_arbiter #(.ADDR_W(18), .STARVE_MAX(4)) dut (.clock(clock), .reset(reset), .bus(bus));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // SRAM model: combinational read, write on the edge; preload port for setup.
  logic [15:0] ram [0:262143];
  logic        pl_en = 1'b0;
  logic [17:0] pl_addr = '0;
  logic [15:0] pl_data = '0;
  assign bus.ram_rdata = ram[bus.ram_addr];
  always @(posedge clock) begin
    if (bus.ram_wre)  ram[bus.ram_addr] <= bus.ram_wdata;
    else if (pl_en)   ram[pl_addr] <= pl_data;
  end

  function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endfunction

  task automatic preload(input logic [17:0] a, input logic [15:0] d);
    pl_addr = a; pl_data = d; pl_en = 1'b1;
    @(posedge clock); #1;
    pl_en = 1'b0;
  endtask

  logic [17:0] sa [4];
  logic        sw [4];
  logic        so [4];
  logic [15:0] sd [4];
  logic        sst[4];

  task automatic access(input bit is_mem, input bit rd, input logic [17:0] a,
                        input logic [31:0] wd, output int lat);
    @(posedge clock); #1;
    if (is_mem) begin
      bus.mem_req = 1'b1; bus.mem_rw = rd; bus.mem_addr = a; bus.mem_wdata = wd;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = a;
    end
    lat = -1;
    for (int c = 0; c < 12 && lat < 0; c++) begin
      @(negedge clock);
      if (c < 4) begin
        sa[c] = bus.ram_addr; sw[c] = bus.ram_wre; so[c] = bus.ram_oe;
        sd[c] = bus.ram_wdata; sst[c] = is_mem ? bus.stall_mem : bus.stall_if;
      end
      if (is_mem ? bus.mem_ack : bus.if_ack) lat = c;
    end
    @(posedge clock); #1;
    bus.if_req = 1'b0; bus.mem_req = 1'b0;
  endtask

  typedef struct {
    bit          is_mem;
    bit          rd;
    logic [17:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;     // requester's rdata after the ack
    logic [31:0] exp_other;  // other port's rdata, must be untouched
  } vec_t;
  vec_t vt [7];

  logic [15:0] refm [32];

  function automatic logic [17:0] rnd_addr();
    return 18'h400 + 18'($urandom_range(0, 31));
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, ma_c, ia_c, n, c;
    logic [31:0] md, id, dat;
    logic [9:0] order;
    bit m_done, i_done;

    vt[0] = '{1'b0, 1'b1, 18'h00100, 32'h0,        32'hDEADBEEF, 32'h0};
    vt[1] = '{1'b1, 1'b0, 18'h00201, 32'h12345678, 32'h0,        32'hDEADBEEF};
    vt[2] = '{1'b1, 1'b1, 18'h00200, 32'h0,        32'h12345678, 32'hDEADBEEF};
    vt[3] = '{1'b1, 1'b0, 18'h3FFFF, 32'hCAFEF00D, 32'h12345678, 32'hDEADBEEF};
    vt[4] = '{1'b0, 1'b1, 18'h3FFFE, 32'h0,        32'hCAFEF00D, 32'h12345678};
    vt[5] = '{1'b1, 1'b0, 18'h00200, 32'hA5A55A5A, 32'h12345678, 32'hCAFEF00D};
    vt[6] = '{1'b0, 1'b1, 18'h00201, 32'h0,        32'hA5A55A5A, 32'h12345678};

    reset = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 18'h100;
    bus.mem_req = 1'b1; bus.mem_rw = 1'b0; bus.mem_addr = 18'h200; bus.mem_wdata = 32'hFFFFFFFF;

    // Reset held with both requests up: every output stays quiet.
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk($sformatf("rst_outs_%0d", i),
          {31'b0, |{bus.if_rdata, bus.mem_rdata, bus.if_ack, bus.mem_ack,
                    bus.ram_addr, bus.ram_wre, bus.ram_oe, bus.ram_wdata}}, 32'h0);
    end
    @(posedge clock); #1;
    preload(18'h100, 16'hBEEF);
    preload(18'h101, 16'hDEAD);
    for (int i = 0; i < 32; i++) begin
      refm[i] = 16'($urandom);
      preload(18'h400 + 18'(i), refm[i]);
    end
    bus.if_req = 1'b0; bus.mem_req = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk($sformatf("idle_bus_%0d", i), {13'b0, bus.ram_addr, bus.ram_oe}, 32'h0);
    end

    // Directed single accesses.
    for (int i = 0; i < 7; i++) begin
      access(vt[i].is_mem, vt[i].rd, vt[i].addr, vt[i].wdata, lat);
      chk($sformatf("v%0d_lat", i), lat, 3);
      chk($sformatf("v%0d_stall0", i), {31'b0, sst[0]}, 1);
      chk($sformatf("v%0d_stall3", i), {31'b0, sst[3]}, 0);
      chk($sformatf("v%0d_addr_lo", i), {14'b0, sa[1]}, {14'b0, vt[i].addr[17:1], 1'b0});
      chk($sformatf("v%0d_addr_hi", i), {14'b0, sa[2]}, {14'b0, vt[i].addr[17:1], 1'b1});
      chk($sformatf("v%0d_wre", i), {29'b0, sw[1], sw[2], sw[3]}, {29'b0, !vt[i].rd, !vt[i].rd, 1'b0});
      chk($sformatf("v%0d_oe", i), {30'b0, so[1], so[2]}, {30'b0, !vt[i].rd, !vt[i].rd});
      if (!vt[i].rd) chk($sformatf("v%0d_wdata", i), {sd[2], sd[1]}, vt[i].wdata);
      chk($sformatf("v%0d_rdata", i), vt[i].is_mem ? bus.mem_rdata : bus.if_rdata, vt[i].exp_rd);
      chk($sformatf("v%0d_other", i), vt[i].is_mem ? bus.if_rdata : bus.mem_rdata, vt[i].exp_other);
    end

    // Collision: MEM wins first, IF follows one slot later.
    @(posedge clock); #1;
    bus.mem_req = 1'b1; bus.mem_rw = 1'b1; bus.mem_addr = 18'h200;
    bus.if_req = 1'b1; bus.if_addr = 18'h100;
    ma_c = -1; ia_c = -1; md = '0; id = '0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clock);
      m_done = bus.mem_ack; i_done = bus.if_ack;
      if (m_done && ma_c < 0) begin ma_c = k; md = bus.mem_rdata; end
      if (i_done && ia_c < 0) begin ia_c = k; id = bus.if_rdata; end
      @(posedge clock); #1;
      if (m_done) bus.mem_req = 1'b0;
      if (i_done) bus.if_req = 1'b0;
    end
    chk("coll_mem_cycle", ma_c, 3);
    chk("coll_mem_data", md, 32'hA5A55A5A);
    chk("coll_if_cycle", ia_c, 7);
    chk("coll_if_data", id, 32'hDEADBEEF);

    // Starvation: both held high, IF forced in after every 4 MEM grants.
    @(posedge clock); #1;
    bus.mem_req = 1'b1; bus.mem_rw = 1'b1; bus.mem_addr = 18'h200;
    bus.if_req = 1'b1; bus.if_addr = 18'h100;
    n = 0; order = '0; c = -1;
    for (int k = 0; k < 80 && n < 10; k++) begin
      @(negedge clock);
      if (bus.if_ack)  begin order[n] = 1'b1; n++; end
      if (bus.mem_ack) begin order[n] = 1'b0; n++; end
      c = k;
    end
    @(posedge clock); #1;
    bus.mem_req = 1'b0; bus.if_req = 1'b0;
    chk("starve_count", n, 10);
    chk("starve_order", {22'b0, order}, 32'h210);
    chk("starve_cycles", c, 39);

    // Reset in the HI phase of a write.
    @(posedge clock); #1;
    bus.mem_req = 1'b1; bus.mem_rw = 1'b0; bus.mem_addr = 18'h300; bus.mem_wdata = 32'h11112222;
    repeat (3) @(negedge clock);
    chk("mid_wre_before", {31'b0, bus.ram_wre}, 1);
    reset = 1'b0;
    #1;
    chk("mid_wre_after", {30'b0, bus.ram_wre, bus.ram_oe}, 0);
    chk("mid_addr_after", {14'b0, bus.ram_addr}, 0);
    bus.mem_req = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    n = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      if (bus.mem_ack) n++;
    end
    chk("mid_no_ack", n, 0);
    chk("mid_rdata_clr", bus.if_rdata | bus.mem_rdata, 0);
    access(1'b0, 1'b1, 18'h100, 32'h0, lat);
    chk("post_rst_lat", lat, 3);
    chk("post_rst_data", bus.if_rdata, 32'hDEADBEEF);

    // Randomized phase against a transaction-level model.
    begin
      int free_c, ack_c, starve, ist, mst, idx;
      bit win_mem, s_rd, gi, gm, ia, ma;
      logic [17:0] s_a;
      logic [31:0] s_wd, last_if, last_mem, exp;
      free_c = 0; ack_c = -10; starve = 0; ist = 0; mst = 0; win_mem = 1'b0;
      s_rd = 1'b0; s_a = '0; s_wd = '0;
      last_if = 32'hDEADBEEF; last_mem = 32'h0;
      for (int k = 0; k < 400; k++) begin
        @(negedge clock);
        ia = (ack_c == k) && !win_mem;
        ma = (ack_c == k) && win_mem;
        chk($sformatf("rnd%0d_if_ack", k), {31'b0, bus.if_ack}, {31'b0, ia});
        chk($sformatf("rnd%0d_mem_ack", k), {31'b0, bus.mem_ack}, {31'b0, ma});
        if (ack_c == k) begin
          idx = int'(s_a - 18'h400) & ~1;
          if (s_rd) begin
            exp = {refm[idx+1], refm[idx]};
            if (win_mem) begin chk($sformatf("rnd%0d_mem_rd", k), bus.mem_rdata, exp); last_mem = exp; end
            else         begin chk($sformatf("rnd%0d_if_rd", k), bus.if_rdata, exp);   last_if = exp; end
          end else begin
            refm[idx] = s_wd[15:0]; refm[idx+1] = s_wd[31:16];
            chk($sformatf("rnd%0d_mem_hold", k), bus.mem_rdata, last_mem);
          end
          chk($sformatf("rnd%0d_other_hold", k), win_mem ? bus.if_rdata : bus.mem_rdata,
              win_mem ? last_if : last_mem);
        end
        gi = 1'b0; gm = 1'b0;
        if (k >= free_c && (bus.if_req || bus.mem_req)) begin
          gi = bus.if_req && (!bus.mem_req || starve == 4);
          gm = !gi;
          if (gi) begin
            starve = 0; s_rd = 1'b1; s_a = bus.if_addr; s_wd = '0;
          end else begin
            if (bus.if_req) starve = (starve < 4) ? starve + 1 : 4;
            s_rd = bus.mem_rw; s_a = bus.mem_addr; s_wd = bus.mem_wdata;
          end
          win_mem = gm; ack_c = k + 3; free_c = k + 4;
        end
        @(posedge clock); #1;
        if (ist == 1 && gi) ist = 2;
        if (ist == 2 && ia) begin ist = 0; bus.if_req = 1'b0; end
        else if (ist == 2) begin
          bus.if_addr = rnd_addr();
          if ($urandom_range(0, 3) == 0) bus.if_req = 1'b0;
        end
        if (ist == 0 && $urandom_range(0, 2) == 0) begin
          bus.if_req = 1'b1; bus.if_addr = rnd_addr(); ist = 1;
        end
        if (mst == 1 && gm) mst = 2;
        if (mst == 2 && ma) begin mst = 0; bus.mem_req = 1'b0; end
        else if (mst == 2) begin
          bus.mem_addr = rnd_addr(); bus.mem_wdata = $urandom; bus.mem_rw = 1'($urandom);
          if ($urandom_range(0, 3) == 0) bus.mem_req = 1'b0;
        end
        if (mst == 0 && $urandom_range(0, 1) == 0) begin
          bus.mem_req = 1'b1; bus.mem_rw = 1'($urandom);
          bus.mem_addr = rnd_addr(); bus.mem_wdata = $urandom; mst = 1;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
